// File: rtl/adder_arb.sv
// Two-requester arbitrated adder: one operand pair is accepted at a time, summed
// by a shared 6-bit prefix adder and returned to the requester that was granted.

module adder_arb_pfx6 (
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic [6:0] s
);

  logic [5:0] p0, g0, p1, g1, p2, g2, g3;

  // Kogge-Stone carry tree: spans 1, 2 and 4 cover all six bit positions.
  always_comb begin
    p0 = x ^ y;
    g0 = x & y;
    p1 = p0;
    g1 = g0;
    p2 = p0;
    g2 = g0;
    g3 = g0;
    for (int i = 1; i < 6; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        g2[i] = g1[i] | (p1[i] & g1[i-2]);
        p2[i] = p1[i] & p1[i-2];
      end else begin
        g2[i] = g1[i];
        p2[i] = p1[i];
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) g3[i] = g2[i] | (p2[i] & g2[i-4]);
      else        g3[i] = g2[i];
    end
    s[0] = p0[0];
    for (int i = 1; i < 6; i++) s[i] = p0[i] ^ g3[i-1];
    s[6] = g3[5];
  end

endmodule

module adder_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [5:0]       req0_x,
  input  logic [5:0]       req0_y,
  input  logic [5:0]       req1_x,
  input  logic [5:0]       req1_y,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [6:0]       rsp_sum,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gid_q, gid_d;
  logic [5:0]       op_x_q, op_x_d, op_y_q, op_y_d;
  logic [6:0]       sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       add_s;
  logic             gnt, accept, rsp_hs;

  adder_arb_pfx6 u_add (
    .x (op_x_q),
    .y (op_y_q),
    .s (add_s)
  );

  // On a tie the requester that did not win last time is served.
  assign gnt    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
  assign rsp_hs = (state_q == RESP) && (gid_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_x_d       = gnt ? req1_x : req0_x;
          op_y_d       = gnt ? req1_y : req0_y;
          gid_d        = gnt;
          last_grant_d = gnt;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        sum_d   = add_s;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
    rsp0_valid = (state_q == RESP) && !gid_q;
    rsp1_valid = (state_q == RESP) && gid_q;
    busy       = (state_q != IDLE);
    rsp_sum    = sum_q;
    done_cnt   = cnt_q;
  end

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-operation counter.
Ports:
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 each, meaning requester n presents an operand pair.
REQ-005 The block SHALL have ports req0_x, req0_y, req1_x and req1_y, input, 6 each, the operand pairs.
REQ-006 The block SHALL have ports req0_ready and req1_ready, output, 1 each, meaning the operands are accepted this cycle.
REQ-007 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 each, meaning the result for requester n is available.
REQ-008 The block SHALL have ports rsp0_ready and rsp1_ready, input, 1 each, meaning requester n takes the result.
REQ-009 The block SHALL have port rsp_sum, output, 7, the result x+y with bit 6 as carry-out, shared by both responses.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done_cnt, output, CNT_W, the count of completed response handshakes.

Function
REQ-012 The block SHALL instantiate exactly one 6-bit prefix adder (ports x[5:0], y[5:0], s[6:0]), fed only from the internal operand registers op_x and op_y.
REQ-013 The block SHALL implement a state machine with states IDLE, EXEC and RESP.
REQ-014 In IDLE with at least one reqN_valid high, the block SHALL grant one requester: if only one is valid, that one; if both are valid, the one not granted last (last_grant register).
REQ-015 The block SHALL drive reqN_ready high combinationally only in IDLE and only for the granted requester; ready SHALL be low in EXEC and RESP.
REQ-016 On the accept edge, the block SHALL capture the granted x and y into op_x and op_y, record the grant id, update last_grant, and enter EXEC.
REQ-017 In EXEC, the block SHALL register the adder output s into rsp_sum on the clock edge and enter RESP; EXEC SHALL last exactly one cycle.
REQ-018 In RESP, the block SHALL hold rspN_valid high only for the recorded grant id, with rsp_sum stable, until rspN_ready is high.
REQ-019 When rspN_valid and rspN_ready are both high, the block SHALL return to IDLE and increment done_cnt, wrapping modulo 2^CNT_W.
REQ-020 The block SHALL ignore rspN_ready of the non-granted requester.
REQ-021 Latency SHALL be: accept at edge T, rspN_valid high during the cycle after edge T+1; with rspN_ready held high, the next accept occurs no earlier than 3 cycles after the previous one.
REQ-022 In IDLE, a new grant SHALL NOT be issued in the same cycle as a response handshake.
REQ-023 When reqN_valid drops without a handshake, the block SHALL take no action; operands are sampled only on accept.
REQ-024 Arithmetic SHALL be unsigned: rsp_sum = {1'b0,x} + {1'b0,y}, range 0..126, with no truncation.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL enter IDLE and abandon any in-flight operation without emitting its response.
REQ-026 On reset, the block SHALL set last_grant = 1 (so req0 wins the first tie), rsp_sum = 0, done_cnt = 0, and op_x = op_y = 0.
REQ-027 During and after reset, reqN_ready, rspN_valid and busy SHALL be 0 until the next grant.

Verification
REQ-028 The bench SHALL cover a single request: req0 with x=25 and y=17 -> req0_ready pulses for 1 cycle; rsp0_valid is high 2 edges later with rsp_sum=42; done_cnt=1.
REQ-029 The bench SHALL cover the carry-out: req1 with x=63 and y=63 -> rsp1_valid with rsp_sum=126 (bit 6 set); rsp0_valid stays 0.
REQ-030 The bench SHALL cover tie fairness after reset: both valid continuously with req0 (1,2) and req1 (3,4) -> grants alternate 0,1,0,1; sums are 3,7,3,7.
REQ-031 The bench SHALL cover backpressure: rsp0_ready held low for 5 cycles -> rsp0_valid and rsp_sum stay stable, busy=1, no new ready; one cycle after rsp0_ready rises, the state is IDLE.
REQ-032 The bench SHALL cover reset mid-operation: rst asserted in EXEC -> no rspN_valid, done_cnt=0, and the next tie is granted to req0.
REQ-033 The bench SHALL cover counter wrap with CNT_W=2: after 4 completed operations, done_cnt=0.
